// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MAR/MDR registers and fixed-wait-state SRAM read/write sequencer
//            with a busy/done handshake towards the control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int WAIT_STATES = 2,
   parameter int DATA_W      = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] BUS_in,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              Mem_Rd_Req,
   input  logic              Mem_Wr_Req,
   input  logic [DATA_W-1:0] Data_from_Mem,
   output logic [DATA_W-1:0] MAR,
   output logic [DATA_W-1:0] MDR,
   output logic [DATA_W-1:0] Data_to_Mem,
   output logic              Mem_CE_n,
   output logic              Mem_OE_n,
   output logic              Mem_WE_n,
   output logic              Mem_Busy,
   output logic              Mem_Done
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_WAIT = 3'd1,
      S_RD_CAP  = 3'd2,
      S_WR_WAIT = 3'd3,
      S_WR_HOLD = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [3:0] c_wait = 4'(WAIT_STATES);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_cnt;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         MAR     <= '0;
         MDR     <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE) begin
            r_cnt <= c_wait;
            if (LD_MAR) MAR <= BUS_in;
            if (LD_MDR) MDR <= BUS_in;
         end else if ((r_state == S_RD_WAIT || r_state == S_WR_WAIT) && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         // Read capture overrides any bus load taken in the request cycle
         if (r_state == S_RD_CAP) MDR <= Data_from_Mem;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (Mem_Rd_Req)      w_next = (WAIT_STATES == 0) ? S_RD_CAP : S_RD_WAIT;
            else if (Mem_Wr_Req) w_next = S_WR_WAIT;
         end
         S_RD_WAIT: if (r_cnt <= 4'd1) w_next = S_RD_CAP;
         S_RD_CAP:  w_next = S_DONE;
         // A zero count still gives one write-strobe cycle
         S_WR_WAIT: if (r_cnt <= 4'd1) w_next = S_WR_HOLD;
         S_WR_HOLD: w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      Mem_CE_n = 1'b1;
      Mem_OE_n = 1'b1;
      Mem_WE_n = 1'b1;
      case (r_state)
         S_RD_WAIT, S_RD_CAP: begin
            Mem_CE_n = 1'b0;
            Mem_OE_n = 1'b0;
         end
         S_WR_WAIT: begin
            Mem_CE_n = 1'b0;
            Mem_WE_n = 1'b0;
         end
         S_WR_HOLD: Mem_CE_n = 1'b0;
         default: ;
      endcase
   end

   assign Mem_Busy    = (r_state != S_IDLE);
   assign Mem_Done    = (r_state == S_DONE);
   assign Data_to_Mem = MDR;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed vector bench for mem_access_unit (W=2 and W=0 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   always #5 Clk = ~Clk;

   // W=2 instance
   logic [15:0] bus, din, mar, mdr, dtm;
   logic        ld_mar, ld_mdr, rd, wr, ce_n, oe_n, we_n, busy, done;

   mem_access_unit #(.WAIT_STATES(2), .DATA_W(16)) u_dut (
      .Clk(Clk), .Reset(Reset), .BUS_in(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
      .Mem_Rd_Req(rd), .Mem_Wr_Req(wr), .Data_from_Mem(din),
      .MAR(mar), .MDR(mdr), .Data_to_Mem(dtm),
      .Mem_CE_n(ce_n), .Mem_OE_n(oe_n), .Mem_WE_n(we_n),
      .Mem_Busy(busy), .Mem_Done(done));

   // W=0 instance
   logic [15:0] bus0, din0, mar0, mdr0, dtm0;
   logic        ld_mar0, ld_mdr0, rd0, wr0, ce0_n, oe0_n, we0_n, busy0, done0;

   mem_access_unit #(.WAIT_STATES(0), .DATA_W(16)) u_dut0 (
      .Clk(Clk), .Reset(Reset), .BUS_in(bus0), .LD_MAR(ld_mar0), .LD_MDR(ld_mdr0),
      .Mem_Rd_Req(rd0), .Mem_Wr_Req(wr0), .Data_from_Mem(din0),
      .MAR(mar0), .MDR(mdr0), .Data_to_Mem(dtm0),
      .Mem_CE_n(ce0_n), .Mem_OE_n(oe0_n), .Mem_WE_n(we0_n),
      .Mem_Busy(busy0), .Mem_Done(done0));

   typedef struct {
      logic        rst;
      logic [15:0] bus;
      logic        ld_mar, ld_mdr, rd, wr;
      logic [15:0] din;
      logic        chk;
      logic [15:0] mar, mdr;
      logic        ce, oe, we, bsy, dn;
   } vec_t;

   vec_t vecs[24];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Outputs of the W=2 instance against expected values
   task automatic check_main(input string tag, input logic [15:0] emar, input logic [15:0] emdr,
                             input logic ece, input logic eoe, input logic ewe,
                             input logic ebsy, input logic edn);
      check({tag, " MAR"}, mar, emar);
      check({tag, " MDR"}, mdr, emdr);
      check({tag, " DTM"}, dtm, emdr);
      check({tag, " CE_n"}, {15'd0, ce_n}, {15'd0, ece});
      check({tag, " OE_n"}, {15'd0, oe_n}, {15'd0, eoe});
      check({tag, " WE_n"}, {15'd0, we_n}, {15'd0, ewe});
      check({tag, " Busy"}, {15'd0, busy}, {15'd0, ebsy});
      check({tag, " Done"}, {15'd0, done}, {15'd0, edn});
   endtask

   task automatic check_w0(input string tag, input logic [15:0] emdr,
                           input logic ece, input logic eoe, input logic ewe,
                           input logic ebsy, input logic edn);
      check({tag, " MDR"}, mdr0, emdr);
      check({tag, " DTM"}, dtm0, emdr);
      check({tag, " CE_n"}, {15'd0, ce0_n}, {15'd0, ece});
      check({tag, " OE_n"}, {15'd0, oe0_n}, {15'd0, eoe});
      check({tag, " WE_n"}, {15'd0, we0_n}, {15'd0, ewe});
      check({tag, " Busy"}, {15'd0, busy0}, {15'd0, ebsy});
      check({tag, " Done"}, {15'd0, done0}, {15'd0, edn});
   endtask

   initial begin
      // Each row: inputs driven this cycle, outputs expected in this same cycle.
      //            rst  bus      lmar lmdr rd  wr  din     chk  MAR      MDR      ce oe we bsy dn
      vecs[0]  = '{1'b1, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1,1,1,0,0};
      vecs[1]  = '{1'b0, 16'h5A5A, 1'b1,1'b1,1'b0,1'b0,16'h0000,1'b1,16'h0000,16'h0000,1,1,1,0,0};
      vecs[2]  = '{1'b1, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h5A5A,16'h5A5A,1,1,1,0,0};
      vecs[3]  = '{1'b1, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0000,16'h0000,1,1,1,0,0};
      // W=2 read from 0x3000
      vecs[4]  = '{1'b0, 16'h3000, 1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0000,16'h0000,1,1,1,0,0};
      vecs[5]  = '{1'b0, 16'h0000, 1'b0,1'b0,1'b1,1'b0,16'hBEEF,1'b1,16'h3000,16'h0000,1,1,1,0,0};
      vecs[6]  = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'hBEEF,1'b1,16'h3000,16'h0000,0,0,1,1,0};
      vecs[7]  = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'hBEEF,1'b1,16'h3000,16'h0000,0,0,1,1,0};
      vecs[8]  = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'hBEEF,1'b1,16'h3000,16'h0000,0,0,1,1,0};
      vecs[9]  = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h3000,16'hBEEF,1,1,1,1,1};
      vecs[10] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h3000,16'hBEEF,1,1,1,0,0};
      // W=2 write 0x1234 to 0x4001, MDR loaded in the request cycle
      vecs[11] = '{1'b0, 16'h4001, 1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h3000,16'hBEEF,1,1,1,0,0};
      vecs[12] = '{1'b0, 16'h1234, 1'b0,1'b1,1'b0,1'b1,16'h0000,1'b1,16'h4001,16'hBEEF,1,1,1,0,0};
      vecs[13] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h4001,16'h1234,0,1,0,1,0};
      vecs[14] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h4001,16'h1234,0,1,0,1,0};
      vecs[15] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h4001,16'h1234,0,1,1,1,0};
      vecs[16] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h4001,16'h1234,1,1,1,1,1};
      vecs[17] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h4001,16'h1234,1,1,1,0,0};
      // Read+write together with LD_MAR: read of new address wins; loads mid-access ignored
      vecs[18] = '{1'b0, 16'h0100, 1'b1,1'b0,1'b1,1'b1,16'h7777,1'b1,16'h4001,16'h1234,1,1,1,0,0};
      vecs[19] = '{1'b0, 16'hFFFF, 1'b1,1'b0,1'b0,1'b1,16'h7777,1'b1,16'h0100,16'h1234,0,0,1,1,0};
      vecs[20] = '{1'b0, 16'hFFFF, 1'b1,1'b1,1'b0,1'b0,16'h7777,1'b1,16'h0100,16'h1234,0,0,1,1,0};
      vecs[21] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b1,1'b1,16'h7777,1'b1,16'h0100,16'h1234,0,0,1,1,0};
      vecs[22] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0000,1'b1,16'h0100,16'h7777,1,1,1,1,1};
      vecs[23] = '{1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0100,16'h7777,1,1,1,0,0};

      bus0 = 16'h0; din0 = 16'h0; ld_mar0 = 1'b0; ld_mdr0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;

      for (int i = 0; i < 24; i++) begin
         Reset  = vecs[i].rst;
         bus    = vecs[i].bus;
         ld_mar = vecs[i].ld_mar;
         ld_mdr = vecs[i].ld_mdr;
         rd     = vecs[i].rd;
         wr     = vecs[i].wr;
         din    = vecs[i].din;
         #1;
         if (vecs[i].chk)
            check_main($sformatf("vec%0d", i), vecs[i].mar, vecs[i].mdr, vecs[i].ce,
                       vecs[i].oe, vecs[i].we, vecs[i].bsy, vecs[i].dn);
         step();
      end
      ld_mar = 1'b0; ld_mdr = 1'b0; rd = 1'b0; wr = 1'b0;

      // W=0 read: RD_CAP in cycle 1, Done in cycle 2
      rd0 = 1'b1; din0 = 16'h1357;
      #1; check_w0("w0rd c0", 16'h0000, 1, 1, 1, 0, 0);
      step(); rd0 = 1'b0;
      check_w0("w0rd c1", 16'h0000, 0, 0, 1, 1, 0);
      step(); din0 = 16'h0000;
      check_w0("w0rd c2", 16'h1357, 1, 1, 1, 1, 1);
      step();
      check_w0("w0rd c3", 16'h1357, 1, 1, 1, 0, 0);

      // W=0 write: WE_n low exactly one cycle, Done in cycle 3
      bus0 = 16'h2468; ld_mdr0 = 1'b1; wr0 = 1'b1;
      step(); ld_mdr0 = 1'b0; wr0 = 1'b0; bus0 = 16'h0000;
      check_w0("w0wr c1", 16'h2468, 0, 1, 0, 1, 0);
      step();
      check_w0("w0wr c2", 16'h2468, 0, 1, 1, 1, 0);
      step();
      check_w0("w0wr c3", 16'h2468, 1, 1, 1, 1, 1);
      step();
      check_w0("w0wr c4", 16'h2468, 1, 1, 1, 0, 0);

      // Reset during RD_WAIT aborts the read with no capture and no Done
      rd = 1'b1; din = 16'hAAAA;
      step(); rd = 1'b0;
      check_main("abort c1", 16'h0100, 16'h7777, 0, 0, 1, 1, 0);
      Reset = 1'b1;
      step(); Reset = 1'b0;
      check_main("abort c2", 16'h0000, 16'h0000, 1, 1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_main($sformatf("abort post%0d", k), 16'h0000, 16'h0000, 1, 1, 1, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
